// File: rtl/brent_kung_pkg.sv
// Shared constants and sizing helpers for the pipelined Brent-Kung adder.
//   bk_levels(width)             : prefix-tree depth, 2*log2(width)-1
//   bk_nstg(width, stage_levels) : register stages, gen + prefix stages + output
package brent_kung_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned bk_levels(input int unsigned width);
    return 2 * $clog2(width) - 1;
  endfunction

  function automatic int unsigned bk_nstg(input int unsigned width,
                                          input int unsigned stage_levels);
    return (bk_levels(width) + stage_levels - 1) / stage_levels + 2;
  endfunction

endpackage

// File: rtl/bk_black_cell.sv
// Brent-Kung black cell: merges a high (g,p) span with the adjacent low span.
//   g_hi, p_hi : generate/propagate of the upper span
//   g_lo, p_lo : generate/propagate of the lower span
//   g, p       : generate/propagate of the merged span
module bk_black_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;

endmodule

// File: rtl/brent_kung_pipe_adder.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready streaming handshakes.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operation handshake (A, B, cin, sub, tag)
//   out_valid/out_ready : result handshake (sum, cout, ovf, tag_out)
// Stage 0 forms p/g (B inverted for sub), the prefix tree is cut into
// register stages every STAGE_LEVELS levels, and the last stage forms the sum.
module brent_kung_pipe_adder
  import brent_kung_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned STAGE_LEVELS = 2,
  parameter int unsigned TAG_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned LOGW = $clog2(WIDTH);
  localparam int unsigned LV   = bk_levels(WIDTH);
  localparam int unsigned NSTG = bk_nstg(WIDTH, STAGE_LEVELS);
  localparam int unsigned NPS  = NSTG - 2;
  localparam int unsigned FS   = NSTG - 1;
  // Sideband per stage: {tag, effective carry-in, bitwise propagate}.
  localparam int unsigned SW   = TAG_W + 1 + WIDTH;

  logic [NSTG-1:0] v;
  logic [NSTG-1:0] rdy;
  logic [NSTG-1:0] en;

  // Ready ripples back from the consumer; an empty stage never blocks.
  always_comb begin
    logic r;
    r   = out_ready;
    rdy = '0;
    en  = '0;
    for (int s = int'(NSTG) - 1; s >= 0; s--) begin
      r      = !v[s] || r;
      rdy[s] = r;
    end
    en[0] = rdy[0] & in_valid;
    for (int s = 1; s < int'(NSTG); s++) begin
      en[s] = rdy[s] & v[s-1];
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[FS];

  // Per-stage valid bits; a stage reloads only when empty or advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
    end else begin
      if (rdy[0]) v[0] <= in_valid;
      for (int s = 1; s < int'(NSTG); s++) begin
        if (rdy[s]) v[s] <= v[s-1];
      end
    end
  end

  // Stage 0: operand conditioning; the carry-in is folded into g[0] so the
  // prefix tree yields carries directly.
  logic [WIDTH-1:0] b_eff, p0, g0;
  logic             c_eff;

  always_comb begin
    b_eff = (sub == OP_SUB) ? ~B : B;
    c_eff = (sub == OP_SUB) ? 1'b1 : cin;
    p0    = A ^ b_eff;
    g0    = A & b_eff;
    g0[0] = g0[0] | (p0[0] & c_eff);
  end

  logic [WIDTH-1:0] s0_g, s0_p;
  logic [SW-1:0]    sd [0:NPS];

  always_ff @(posedge clk) begin
    if (en[0]) begin
      s0_g  <= g0;
      s0_p  <= p0;
      sd[0] <= {tag, c_eff, p0};
    end
  end

  // Prefix tree: levels 1..LOGW up-sweep, the rest down-sweep.
  for (genvar k = 1; k <= LV; k++) begin : g_lvl
    localparam bit          UP   = (k <= LOGW);
    localparam int unsigned DIST = UP ? (1 << (k - 1)) : (1 << (2 * LOGW - 1 - k));
    localparam bit          REG  = ((k % STAGE_LEVELS) == 0) || (k == LV);
    localparam int unsigned STG  = (k + STAGE_LEVELS - 1) / STAGE_LEVELS;

    logic [WIDTH-1:0] ig, ip, cg, cp, og, op;

    if (k == 1) begin : g_in
      assign ig = s0_g;
      assign ip = s0_p;
    end else begin : g_in
      assign ig = g_lvl[k-1].og;
      assign ip = g_lvl[k-1].op;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if ((UP && (((i + 1) % (2 * DIST)) == 0)) ||
          (!UP && (((i + 1) % (2 * DIST)) == DIST) && ((i + 1) > DIST))) begin : g_cell
        bk_black_cell u_cell (
          .g_hi (ig[i]),
          .p_hi (ip[i]),
          .g_lo (ig[i-DIST]),
          .p_lo (ip[i-DIST]),
          .g    (cg[i]),
          .p    (cp[i])
        );
      end else begin : g_pass
        assign cg[i] = ig[i];
        assign cp[i] = ip[i];
      end
    end

    if (REG) begin : g_reg
      logic [WIDTH-1:0] rg, rp;
      always_ff @(posedge clk) begin
        if (en[STG]) begin
          rg <= cg;
          rp <= cp;
        end
      end
      assign og = rg;
      assign op = rp;
    end else begin : g_comb
      assign og = cg;
      assign op = cp;
    end
  end

  // Sideband follows the prefix register stages.
  for (genvar s = 1; s <= NPS; s++) begin : g_sd
    always_ff @(posedge clk) begin
      if (en[s]) sd[s] <= sd[s-1];
    end
  end

  // Final stage: carries are the full-span prefix generates.
  logic [WIDTH-1:0] gf;
  logic             unused_p;

  assign gf       = g_lvl[LV].og;
  assign unused_p = ^g_lvl[LV].op;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      tag_out <= '0;
    end else if (en[FS]) begin
      sum     <= sd[NPS][WIDTH-1:0] ^ {gf[WIDTH-2:0], sd[NPS][WIDTH]};
      cout    <= gf[WIDTH-1];
      ovf     <= gf[WIDTH-1] ^ gf[WIDTH-2];
      tag_out <= sd[NPS][SW-1 -: TAG_W];
    end
  end

endmodule

// File: tb/tb_brent_kung_pipe_adder.sv
// Scoreboard bench for brent_kung_pipe_adder at WIDTH=16, default staging.
module tb_brent_kung_pipe_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0, B = '0;
  logic        cin = 1'b0, sub = 1'b0;
  logic [3:0]  tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout, ovf;
  logic [3:0]  tag_out;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  int   total_rets = 0;
  int   streak = 0;
  int   last_ret = -10;
  exp_t sbq[$];

  brent_kung_pipe_adder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .cin(cin), .sub(sub), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .tag_out(tag_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer readiness: 0 = stalled, 1 = always ready, else random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic s, input logic [3:0] t);
    exp_t        e;
    logic [15:0] bb;
    logic [16:0] r;
    bb     = s ? ~b : b;
    r      = {1'b0, a} + {1'b0, bb} + 17'(s ? 1'b1 : ci);
    e.sum  = r[15:0];
    e.cout = r[16];
    e.ovf  = (a[15] == bb[15]) && (r[15] != a[15]);
    e.tag  = t;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e, g;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        g = '{sum: sum, cout: cout, ovf: ovf, tag: tag_out};
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got sum=%h cout=%b ovf=%b tag=%h with empty scoreboard",
                   sum, cout, ovf, tag_out);
        end else begin
          e = sbq.pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL result: got sum=%h cout=%b ovf=%b tag=%h expected sum=%h cout=%b ovf=%b tag=%h",
                     g.sum, g.cout, g.ovf, g.tag, e.sum, e.cout, e.ovf, e.tag);
          end
        end
        streak   = (last_ret == cyc - 1) ? streak + 1 : 1;
        last_ret = cyc;
        total_rets++;
      end
    end
  endtask

  // Present one op, wait (bounded) for acceptance, push its expectation.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic s, input logic [3:0] t, input exp_t e);
    int n;
    A = a; B = b; cin = ci; sub = s; tag = t; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("accept", 32'(in_ready), 32'd1);
    if (in_ready) sbq.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("drain", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic measure_lat(input string name);
    int lat;
    lat = -1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = j;
        break;
      end
    end
    chk(name, 32'(lat), 32'd5);
  endtask

  initial begin
    int         acc;
    logic [15:0] ra, rb, hs;
    logic       rc, rs;
    logic [3:0] ht;

    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_flags", {30'd0, cout, ovf}, 32'd0);
    chk("rst_tag_out", 32'(tag_out), 32'd0);

    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;

    // Directed vectors with hand-computed results.
    send(16'h01E0, 16'h000F, 1'b0, 1'b0, 4'd3, '{16'h01EF, 1'b0, 1'b0, 4'd3});
    measure_lat("latency_first");
    wait_drain();
    send(16'h01E0, 16'h000F, 1'b1, 1'b0, 4'd4, '{16'h01F0, 1'b0, 1'b0, 4'd4});
    send(16'hF1E0, 16'hF00F, 1'b1, 1'b0, 4'd5, '{16'hE1F0, 1'b1, 1'b0, 4'd5});
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 4'd6, '{16'hFFFE, 1'b0, 1'b0, 4'd6});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 4'd7, '{16'h7FFF, 1'b1, 1'b1, 4'd7});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'd8, '{16'h8000, 1'b0, 1'b1, 4'd8});
    wait_drain();

    // Back-to-back stream: results must retire on consecutive cycles.
    for (int i = 0; i < 20; i++) begin
      ra = 16'(i * 16'h0311); rb = 16'(16'h1234 + i);
      send(ra, rb, 1'b0, 1'(i % 2), 4'(i), model(ra, rb, 1'b0, 1'(i % 2), 4'(i)));
    end
    wait_drain();
    chk("stream_streak", 32'(streak), 32'd20);

    // Fill with consumer stalled: exactly NSTG accepts, outputs hold.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      ra = 16'(16'hA000 + acc); rb = 16'(acc * 7);
      A = ra; B = rb; cin = 1'b1; sub = 1'b0; tag = 4'(acc); in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(model(ra, rb, 1'b1, 1'b0, 4'(acc)));
        acc++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_accepts", 32'(acc), 32'd6);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    hs = sum; ht = tag_out;
    repeat (4) @(negedge clk);
    chk("hold_sum", 32'(sum), 32'(hs));
    chk("hold_tag", 32'(tag_out), 32'(ht));
    acc = total_rets;
    rdy_mode = 1;
    wait_drain();
    chk("release_count", 32'(total_rets - acc), 32'd6);

    // Random gaps and random consumer backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      if (i % 50 == 0) begin ra = 16'h7FFF; rb = 16'h8000; end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(ra, rb, rc, rs, 4'(i), model(ra, rb, rc, rs, 4'(i)));
    end
    rdy_mode = 1;
    wait_drain();

    // Reset with four ops in flight plus a coincident accept attempt.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) begin
      send(16'(i), 16'(i), 1'b0, 1'b0, 4'(i), model(16'(i), 16'(i), 1'b0, 1'b0, 4'(i)));
    end
    rst = 1'b1;
    A = 16'hDEAD; B = 16'hBEEF; tag = 4'hF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    sbq.delete();
    rdy_mode = 1;
    @(negedge clk);
    chk("rst_flush_valid", 32'(out_valid), 32'd0);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) acc++;
    end
    chk("rst_no_stale", 32'(acc), 32'd0);
    @(posedge clk);
    #1;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 4'hA, '{16'h2345, 1'b0, 1'b0, 4'hA});
    measure_lat("latency_after_rst");
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
